ramcard_sram_seq: RTL and testbench

- Downstream of the language-card/Saturn bank mapper.
- Takes CPU accesses already translated to an 18-bit card RAM address, plus the mapper's read/write enables, and runs timed cycles on an external async 8-bit SRAM.
- Interleaves video fetches from main 64K with priority, and tells the bus when ROM must answer instead of card RAM.

---
 rtl/ramcard_sram_seq_pkg.sv | 54 +++++
 rtl/ramcard_sram_seq_if.sv | 58 +++++
 rtl/ramcard_sram_seq_req_slot.sv | 60 ++++++
 rtl/ramcard_sram_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_ramcard_sram_seq.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ramcard_sram_seq_pkg.sv
// ramcard_sram_seq_pkg
// Shared types and constants for the card-RAM SRAM sequencer:
//   - SRAM geometry (18-bit address, 8-bit data) and video address width
//   - sequencer FSM states and request-source encoding
//   - CPU access classification (RAM / write-protected / ROM) and its helper
//   - the transaction record held in each request slot
package ramcard_sram_seq_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 8;
    localparam int VID_AW  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        CLS_RAM   = 2'd0,
        CLS_WPROT = 2'd1,
        CLS_ROM   = 2'd2
    } cpu_class_e;

    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_VID = 1'b1
    } src_e;

    typedef struct packed {
        logic [SRAM_AW-1:0] addr;
        logic               we;
        logic [SRAM_DW-1:0] wdata;
    } sram_txn_t;

    localparam int TXN_W = $bits(sram_txn_t);

    // Inside the card window the mapper may refuse the access: a refused write
    // is silently absorbed, a refused read must be answered by ROM instead.
    function automatic cpu_class_e classify(input logic card_sel, input logic we,
                                            input logic ram_we, input logic ram_rd);
        cpu_class_e cls;
        if (card_sel && we && !ram_we) begin
            cls = CLS_WPROT;
        end else if (card_sel && !we && !ram_rd) begin
            cls = CLS_ROM;
        end else begin
            cls = CLS_RAM;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ramcard_sram_seq_if.sv
// ramcard_sram_seq_if
// Bundles the CPU request port, the video fetch port, the overrun flag and the
// external async SRAM pins of the sequencer.
//   slave  : the sequencer's view (takes requests, drives SRAM pins)
//   master : the environment's view (issues requests, models the SRAM)
interface ramcard_sram_seq_if;
    import ramcard_sram_seq_pkg::*;

    // CPU port
    logic               cpu_req;
    logic [SRAM_AW-1:0] cpu_addr;
    logic               cpu_we;
    logic               cpu_card_sel;
    logic               card_ram_we;
    logic               card_ram_rd;
    logic [SRAM_DW-1:0] cpu_wdata;
    logic [SRAM_DW-1:0] cpu_rdata;
    logic               cpu_ack;
    logic               cpu_ram_hit;

    // Video port
    logic               vid_req;
    logic [VID_AW-1:0]  vid_addr;
    logic [SRAM_DW-1:0] vid_rdata;
    logic               vid_ack;

    logic               req_overrun;

    // SRAM pins
    logic [SRAM_AW-1:0] sram_addr;
    logic [SRAM_DW-1:0] sram_dq_o;
    logic [SRAM_DW-1:0] sram_dq_i;
    logic               sram_dq_oe;
    logic               sram_ce_n;
    logic               sram_oe_n;
    logic               sram_we_n;

    modport slave (
        input  cpu_req, cpu_addr, cpu_we, cpu_card_sel, card_ram_we, card_ram_rd, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_ram_hit,
        input  vid_req, vid_addr,
        output vid_rdata, vid_ack,
        output req_overrun,
        output sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
        input  sram_dq_i
    );

    modport master (
        output cpu_req, cpu_addr, cpu_we, cpu_card_sel, card_ram_we, card_ram_rd, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_ram_hit,
        output vid_req, vid_addr,
        input  vid_rdata, vid_ack,
        input  req_overrun,
        input  sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
        output sram_dq_i
    );

endinterface

// File: rtl/ramcard_sram_seq_req_slot.sv
// ramcard_req_slot
// One-deep request holding slot.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request pulse from the source
//   queue      : 1 = accepted request must wait for the sequencer (sets pending)
//   clear      : sequencer finishes the pending request this cycle
//   din / dout : transaction record in / latched record out
//   pending    : a request is waiting or in service
//   accept     : this cycle's req is taken (slot free, or being cleared)
//   overrun    : this cycle's req is dropped because the slot is occupied
module ramcard_req_slot #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req,
    input  logic         queue,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         pending,
    output logic [W-1:0] dout,
    output logic         accept,
    output logic         overrun
);

    logic         pending_q, pending_d;
    logic [W-1:0] data_q, data_d;

    // A slot being cleared this cycle counts as free, so a request arriving
    // on the final cycle of service is taken rather than flagged.
    always_comb begin
        pending_d = pending_q;
        data_d    = data_q;
        accept    = req && (!pending_q || clear);
        overrun   = req && pending_q && !clear;
        if (accept) begin
            pending_d = queue;
            data_d    = din;
        end else if (clear) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Slot state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            data_q    <= '0;
        end else begin
            pending_q <= pending_d;
            data_q    <= data_d;
        end
    end

    assign pending = pending_q;
    assign dout    = data_q;

endmodule

// File: rtl/ramcard_sram_seq.sv
// ramcard_sram_seq
// Runs timed cycles on an external async 8-bit SRAM for CPU accesses coming
// from the language-card bank mapper and for video fetches, video first.
// CPU accesses the mapper refuses are answered the next clock without an
// SRAM cycle (absorbed write, or a read that ROM must supply).
//   mclk28  : system clock, all state on the rising edge
//   reset_n : asynchronous active-low reset; strobes release immediately
//   bus     : CPU port, video port, overrun flag and SRAM pins (slave view)
// Parameters:
//   ACCESS_CYCLES : clocks WE_n/OE_n are held active per access (1..7)
//   VID_BASE      : SRAM base added to the 16-bit video address
module ramcard_sram_seq
    import ramcard_sram_seq_pkg::*;
#(
    parameter int                 ACCESS_CYCLES = 2,
    parameter logic [SRAM_AW-1:0] VID_BASE      = 18'h00000
) (
    input  logic                 mclk28,
    input  logic                 reset_n,
    ramcard_sram_seq_if.slave    bus
);

    localparam logic [2:0] ACC_LAST = 3'(ACCESS_CYCLES - 1);

    // Sequencer state and registered outputs
    seq_state_e         state_q, state_d;
    src_e               src_q, src_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [SRAM_DW-1:0] dq_o_q, dq_o_d;
    logic               dq_oe_q, dq_oe_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               cpu_ack_q, cpu_ack_d;
    logic               cpu_hit_q, cpu_hit_d;
    logic [SRAM_DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic               vid_ack_q, vid_ack_d;
    logic [SRAM_DW-1:0] vid_rdata_q, vid_rdata_d;
    logic               ovr_q, ovr_d;

    // Slot interface
    cpu_class_e cpu_class_s;
    sram_txn_t  cpu_din_s, vid_din_s;
    sram_txn_t  cpu_txn_s, vid_txn_s;
    logic       cpu_pend_s, vid_pend_s;
    logic       cpu_accept_s, vid_accept_s;
    logic       cpu_ovr_s, vid_ovr_s;
    logic       cpu_clear_s, vid_clear_s;
    logic       cpu_ready_s, vid_ready_s;
    logic       launch_any_s;
    src_e       launch_src_s;
    sram_txn_t  launch_txn_s;
    sram_txn_t  cur_txn_s;

    assign cpu_class_s = classify(bus.cpu_card_sel, bus.cpu_we, bus.card_ram_we, bus.card_ram_rd);
    assign cpu_din_s   = '{addr: bus.cpu_addr, we: bus.cpu_we, wdata: bus.cpu_wdata};
    // Video is read-only; the 18-bit sum wraps naturally.
    assign vid_din_s   = '{addr: VID_BASE + {2'b00, bus.vid_addr}, we: 1'b0, wdata: 8'h00};

    // The slot in service is released on its HOLD clock.
    assign cpu_clear_s = (state_q == ST_HOLD) && (src_q == SRC_CPU);
    assign vid_clear_s = (state_q == ST_HOLD) && (src_q == SRC_VID);

    ramcard_req_slot #(.W(TXN_W)) u_cpu_slot (
        .clk     (mclk28),
        .rst_n   (reset_n),
        .req     (bus.cpu_req),
        .queue   (cpu_class_s == CLS_RAM),
        .clear   (cpu_clear_s),
        .din     (cpu_din_s),
        .pending (cpu_pend_s),
        .dout    (cpu_txn_s),
        .accept  (cpu_accept_s),
        .overrun (cpu_ovr_s)
    );

    ramcard_req_slot #(.W(TXN_W)) u_vid_slot (
        .clk     (mclk28),
        .rst_n   (reset_n),
        .req     (bus.vid_req),
        .queue   (1'b1),
        .clear   (vid_clear_s),
        .din     (vid_din_s),
        .pending (vid_pend_s),
        .dout    (vid_txn_s),
        .accept  (vid_accept_s),
        .overrun (vid_ovr_s)
    );

    // A slot finishing in HOLD is not a candidate for the next cycle; the
    // other slot is, which gives back-to-back service with no idle gap.
    assign cpu_ready_s  = cpu_pend_s && !cpu_clear_s;
    assign vid_ready_s  = vid_pend_s && !vid_clear_s;
    assign launch_any_s = cpu_ready_s || vid_ready_s;
    assign launch_src_s = vid_ready_s ? SRC_VID : SRC_CPU;
    assign launch_txn_s = vid_ready_s ? vid_txn_s : cpu_txn_s;
    assign cur_txn_s    = (src_q == SRC_VID) ? vid_txn_s : cpu_txn_s;

    // Next-state and next-output logic of the sequencer
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = dq_oe_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        cpu_ack_d   = 1'b0;
        cpu_hit_d   = cpu_hit_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_ack_d   = 1'b0;
        vid_rdata_d = vid_rdata_q;
        ovr_d       = ovr_q | cpu_ovr_s | vid_ovr_s;

        // Refused CPU accesses complete on the next clock without touching
        // the SRAM. They can never collide with an SRAM ack: while the CPU
        // slot is in service it is occupied, so nothing is accepted.
        if (cpu_accept_s && (cpu_class_s != CLS_RAM)) begin
            cpu_ack_d = 1'b1;
            cpu_hit_d = (cpu_class_s == CLS_WPROT);
        end else begin
            cpu_ack_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (launch_any_s) begin
                    state_d = ST_SETUP;
                    src_d   = launch_src_s;
                    addr_d  = launch_txn_s.addr;
                    dq_o_d  = launch_txn_s.wdata;
                    dq_oe_d = launch_txn_s.we;
                    ce_n_d  = 1'b0;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    dq_oe_d = 1'b0;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = ACC_LAST;
                oe_n_d  = cur_txn_s.we;
                we_n_d  = !cur_txn_s.we;
            end
            ST_ACCESS: begin
                if (cnt_q == 3'd0) begin
                    // Last access clock: capture read data and raise the ack
                    // so both are valid during HOLD.
                    state_d = ST_HOLD;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    if (src_q == SRC_VID) begin
                        vid_ack_d = 1'b1;
                        if (!cur_txn_s.we) begin
                            vid_rdata_d = bus.sram_dq_i;
                        end else begin
                            vid_rdata_d = vid_rdata_q;
                        end
                    end else begin
                        cpu_ack_d = 1'b1;
                        cpu_hit_d = 1'b1;
                        if (!cur_txn_s.we) begin
                            cpu_rdata_d = bus.sram_dq_i;
                        end else begin
                            cpu_rdata_d = cpu_rdata_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dq_oe_d = 1'b0;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
            end
        endcase
    end

    // Sequencer registers; reset releases all SRAM strobes at once
    always_ff @(posedge mclk28 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_CPU;
            cnt_q       <= 3'd0;
            addr_q      <= 18'h00000;
            dq_o_q      <= 8'h00;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            cpu_ack_q   <= 1'b0;
            cpu_hit_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
            vid_ack_q   <= 1'b0;
            vid_rdata_q <= 8'h00;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_hit_q   <= cpu_hit_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_ack_q   <= vid_ack_d;
            vid_rdata_q <= vid_rdata_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_o   = dq_o_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_ce_n   = ce_n_q;
    assign bus.sram_oe_n   = oe_n_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.cpu_ram_hit = cpu_hit_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.vid_ack     = vid_ack_q;
    assign bus.vid_rdata   = vid_rdata_q;
    assign bus.req_overrun = ovr_q;

endmodule

// File: tb/tb_ramcard_sram_seq.sv
// tb_ramcard_sram_seq
// Directed scenarios followed by randomized traffic. A transaction-level
// model (request slots as flags, service as a busy window ending at a HOLD
// cycle number, a reference byte array for memory contents) predicts acks,
// read data, overrun and the SRAM strobe windows; one process compares the
// DUT against it every cycle. Directed steps add literal expectations.
module tb_ramcard_sram_seq;
    import ramcard_sram_seq_pkg::*;

    localparam int AC = 2;
    localparam logic [17:0] VBASE = 18'h00000;

    logic mclk28 = 1'b0;
    logic reset_n = 1'b0;
    always #5 mclk28 = ~mclk28;

    ramcard_sram_seq_if bus();

    ramcard_sram_seq #(.ACCESS_CYCLES(AC), .VID_BASE(VBASE)) dut (
        .mclk28  (mclk28),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input int a);
        logic [17:0] av;
        av = 18'(a);
        return av[7:0] ^ av[15:8] ^ 8'h3C;
    endfunction

    // External async SRAM model
    logic [7:0] sram_mem [0:262143];
    logic [7:0] ref_mem  [0:262143];
    assign bus.sram_dq_i = (!bus.sram_ce_n && !bus.sram_oe_n) ? sram_mem[bus.sram_addr] : 8'hEE;

    initial begin
        for (int i = 0; i < 262144; i++) begin
            sram_mem[i] = init_byte(i);
            ref_mem[i]  = init_byte(i);
        end
        forever begin
            @(negedge mclk28);
            if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe)
                sram_mem[bus.sram_addr] = bus.sram_dq_o;
        end
    end

    // Reference model state
    int         cyc = 0;
    bit         m_cpu_pend, m_vid_pend, m_busy, m_busy_vid;
    logic [17:0] m_cpu_addr, m_vid_addr, m_addr;
    bit         m_cpu_we, m_we;
    logic [7:0] m_cpu_wdata, m_wdata;
    int         m_hold = -10;
    bit         exp_cpu_ack, exp_hit, exp_vid_ack, exp_ovr;
    logic [7:0] exp_cpu_rdata, exp_vid_rdata;

    initial begin
        forever begin
            @(posedge mclk28 or negedge reset_n);
            if (!reset_n) begin
                cyc = 0; m_cpu_pend = 0; m_vid_pend = 0; m_busy = 0; m_hold = -10;
                exp_cpu_ack = 0; exp_hit = 0; exp_vid_ack = 0; exp_ovr = 0;
                exp_cpu_rdata = 8'h00; exp_vid_rdata = 8'h00;
            end else begin
                cyc++;
                exp_cpu_ack = 0;
                exp_vid_ack = 0;
                // service ended last cycle: its slot frees at this edge
                if (m_busy && m_hold == cyc - 1) begin
                    if (m_busy_vid) m_vid_pend = 0; else m_cpu_pend = 0;
                    m_busy = 0;
                end
                // start a new service (video first), SETUP this cycle
                if (!m_busy && (m_vid_pend || m_cpu_pend)) begin
                    m_busy = 1;
                    m_busy_vid = m_vid_pend;
                    m_hold = cyc + AC + 1;
                    if (m_vid_pend) begin
                        m_addr = m_vid_addr; m_we = 0; m_wdata = 8'h00;
                    end else begin
                        m_addr = m_cpu_addr; m_we = m_cpu_we; m_wdata = m_cpu_wdata;
                    end
                end
                // new requests
                if (bus.cpu_req) begin
                    if (m_cpu_pend) exp_ovr = 1;
                    else if (bus.cpu_card_sel && bus.cpu_we && !bus.card_ram_we) begin
                        exp_cpu_ack = 1; exp_hit = 1;
                    end else if (bus.cpu_card_sel && !bus.cpu_we && !bus.card_ram_rd) begin
                        exp_cpu_ack = 1; exp_hit = 0;
                    end else begin
                        m_cpu_pend = 1; m_cpu_addr = bus.cpu_addr;
                        m_cpu_we = bus.cpu_we; m_cpu_wdata = bus.cpu_wdata;
                    end
                end
                if (bus.vid_req) begin
                    if (m_vid_pend) exp_ovr = 1;
                    else begin
                        m_vid_pend = 1;
                        m_vid_addr = 18'(VBASE + {2'b00, bus.vid_addr});
                    end
                end
                // HOLD cycle: completion
                if (m_busy && m_hold == cyc) begin
                    if (m_we) ref_mem[m_addr] = m_wdata;
                    if (m_busy_vid) begin
                        exp_vid_ack = 1; exp_vid_rdata = ref_mem[m_addr];
                    end else begin
                        exp_cpu_ack = 1; exp_hit = 1;
                        if (!m_we) exp_cpu_rdata = ref_mem[m_addr];
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        bit exp_we_act, exp_oe_act;
        forever begin
            @(negedge mclk28);
            if (reset_n) begin
                exp_we_act = m_busy && m_we && (cyc >= m_hold - AC) && (cyc <= m_hold - 1);
                exp_oe_act = m_busy && !m_we && (cyc >= m_hold - AC) && (cyc <= m_hold - 1);
                chk("cpu_ack", 32'(bus.cpu_ack), 32'(exp_cpu_ack));
                if (exp_cpu_ack) chk("cpu_ram_hit", 32'(bus.cpu_ram_hit), 32'(exp_hit));
                chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_cpu_rdata));
                chk("vid_ack", 32'(bus.vid_ack), 32'(exp_vid_ack));
                chk("vid_rdata", 32'(bus.vid_rdata), 32'(exp_vid_rdata));
                chk("req_overrun", 32'(bus.req_overrun), 32'(exp_ovr));
                chk("sram_ce_n", 32'(bus.sram_ce_n), 32'(!m_busy));
                chk("sram_we_n", 32'(bus.sram_we_n), 32'(!exp_we_act));
                chk("sram_oe_n", 32'(bus.sram_oe_n), 32'(!exp_oe_act));
                chk("sram_dq_oe", 32'(bus.sram_dq_oe), 32'(m_busy && m_we));
                if (m_busy) chk("sram_addr", 32'(bus.sram_addr), 32'(m_addr));
                if (m_busy && m_we) chk("sram_dq_o", 32'(bus.sram_dq_o), 32'(m_wdata));
            end
        end
    end

    task automatic drive_cpu(input logic [17:0] a, input bit we, input logic [7:0] d,
                             input bit sel, input bit rwe, input bit rrd);
        bus.cpu_addr = a; bus.cpu_we = we; bus.cpu_wdata = d;
        bus.cpu_card_sel = sel; bus.card_ram_we = rwe; bus.card_ram_rd = rrd;
        bus.cpu_req = 1'b1;
    endtask

    // One CPU request; lat = clocks from the request cycle to the ack cycle
    task automatic cpu_txn(input logic [17:0] a, input bit we, input logic [7:0] d,
                           input bit sel, input bit rwe, input bit rrd, output int lat);
        @(posedge mclk28); #1;
        drive_cpu(a, we, d, sel, rwe, rrd);
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(posedge mclk28); #1;
            if (k == 1) bus.cpu_req = 1'b0;
            if (bus.cpu_ack) lat = k;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, vlat, clat, nack;
        bus.cpu_req = 0; bus.cpu_addr = '0; bus.cpu_we = 0; bus.cpu_card_sel = 0;
        bus.card_ram_we = 0; bus.card_ram_rd = 0; bus.cpu_wdata = '0;
        bus.vid_req = 0; bus.vid_addr = '0;

        // Reset values
        repeat (3) @(posedge mclk28);
        #1;
        chk("rst cpu_ack", 32'(bus.cpu_ack), 32'd0);
        chk("rst vid_ack", 32'(bus.vid_ack), 32'd0);
        chk("rst cpu_rdata", 32'(bus.cpu_rdata), 32'h00);
        chk("rst vid_rdata", 32'(bus.vid_rdata), 32'h00);
        chk("rst cpu_ram_hit", 32'(bus.cpu_ram_hit), 32'd0);
        chk("rst ce_n", 32'(bus.sram_ce_n), 32'd1);
        chk("rst oe_n", 32'(bus.sram_oe_n), 32'd1);
        chk("rst we_n", 32'(bus.sram_we_n), 32'd1);
        chk("rst dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        chk("rst sram_addr", 32'(bus.sram_addr), 32'h0);
        chk("rst overrun", 32'(bus.req_overrun), 32'd0);
        @(negedge mclk28);
        reset_n = 1'b1;

        // RAM write then read back
        cpu_txn(18'h10123, 1, 8'hA5, 1, 1, 1, lat);
        chk("wr latency", 32'(lat), 32'd5);
        cpu_txn(18'h10123, 0, 8'h00, 1, 1, 1, lat);
        chk("rd latency", 32'(lat), 32'd5);
        chk("rd data", 32'(bus.cpu_rdata), 32'hA5);
        chk("rd hit", 32'(bus.cpu_ram_hit), 32'd1);

        // Write-protected write is absorbed
        cpu_txn(18'h0D000, 1, 8'h5A, 1, 0, 1, lat);
        chk("wprot latency", 32'(lat), 32'd1);
        chk("wprot hit", 32'(bus.cpu_ram_hit), 32'd1);
        cpu_txn(18'h0D000, 0, 8'h00, 1, 1, 1, lat);
        chk("wprot readback", 32'(bus.cpu_rdata), 32'hEC);

        // ROM read: no SRAM cycle, rdata keeps its last value
        cpu_txn(18'h0E000, 0, 8'h00, 1, 1, 0, lat);
        chk("rom latency", 32'(lat), 32'd1);
        chk("rom hit", 32'(bus.cpu_ram_hit), 32'd0);
        chk("rom ce_n", 32'(bus.sram_ce_n), 32'd1);
        chk("rom rdata hold", 32'(bus.cpu_rdata), 32'hEC);

        // Contention: video first, CPU right behind
        @(posedge mclk28); #1;
        drive_cpu(18'h10123, 0, 8'h00, 1, 1, 1);
        bus.vid_addr = 16'h0400; bus.vid_req = 1'b1;
        vlat = -1; clat = -1;
        for (int k = 1; k <= 15 && clat < 0; k++) begin
            @(posedge mclk28); #1;
            if (k == 1) begin bus.cpu_req = 1'b0; bus.vid_req = 1'b0; end
            if (k == 2) chk("contention first addr", 32'(bus.sram_addr), 32'h00400);
            if (bus.vid_ack && vlat < 0) begin
                vlat = k;
                chk("contention vid data", 32'(bus.vid_rdata), 32'h38);
            end
            if (bus.cpu_ack) clat = k;
        end
        chk("contention vid latency", 32'(vlat), 32'd5);
        chk("contention cpu latency", 32'(clat), 32'd9);
        chk("contention cpu data", 32'(bus.cpu_rdata), 32'hA5);

        // Overrun: back-to-back CPU requests, second one dropped
        @(posedge mclk28); #1;
        chk("pre overrun", 32'(bus.req_overrun), 32'd0);
        drive_cpu(18'h00011, 1, 8'h77, 0, 0, 0);
        nack = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge mclk28); #1;
            if (k == 1) bus.cpu_wdata = 8'h88;
            if (k == 2) bus.cpu_req = 1'b0;
            if (bus.cpu_ack) nack++;
        end
        chk("overrun ack count", 32'(nack), 32'd1);
        chk("overrun flag", 32'(bus.req_overrun), 32'd1);
        cpu_txn(18'h00011, 0, 8'h00, 0, 0, 0, lat);
        chk("overrun kept first", 32'(bus.cpu_rdata), 32'h77);
        chk("overrun sticky", 32'(bus.req_overrun), 32'd1);

        // Async reset in the middle of a write
        @(posedge mclk28); #1;
        drive_cpu(18'h00022, 1, 8'h99, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge mclk28); #1;
            if (k == 1) bus.cpu_req = 1'b0;
        end
        chk("mid-access we_n", 32'(bus.sram_we_n), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("async rst we_n", 32'(bus.sram_we_n), 32'd1);
        chk("async rst ce_n", 32'(bus.sram_ce_n), 32'd1);
        chk("async rst dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        chk("async rst ack", 32'(bus.cpu_ack), 32'd0);
        repeat (2) @(negedge mclk28);
        reset_n = 1'b1;
        chk("post rst state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("post rst overrun", 32'(bus.req_overrun), 32'd0);
        cpu_txn(18'h00022, 0, 8'h00, 0, 0, 0, lat);
        chk("interrupted write lat", 32'(lat), 32'd5);
        chk("interrupted write data", 32'(bus.cpu_rdata), 32'h1E);

        // Randomized traffic against the model
        for (int i = 0; i < 1200; i++) begin
            @(posedge mclk28); #1;
            bus.cpu_req      = ($urandom_range(0, 5) == 0);
            bus.cpu_addr     = {2'($urandom_range(0, 3)), 12'h000, 4'($urandom_range(0, 15))};
            bus.cpu_we       = 1'($urandom_range(0, 1));
            bus.cpu_wdata    = 8'($urandom_range(0, 255));
            bus.cpu_card_sel = 1'($urandom_range(0, 1));
            bus.card_ram_we  = ($urandom_range(0, 3) != 0);
            bus.card_ram_rd  = ($urandom_range(0, 3) != 0);
            bus.vid_req      = ($urandom_range(0, 5) == 0);
            bus.vid_addr     = {12'h000, 4'($urandom_range(0, 15))};
        end
        @(posedge mclk28); #1;
        bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
        repeat (30) @(posedge mclk28);
        @(negedge mclk28);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
